// File: rtl/t1_block_scheduler.sv
// T1 block scheduler: stamps each T1 with its starting block, queues it in a small
// event FIFO and issues the event one block at a time over a req/ack handshake.
module t1_block_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_BITS   = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [8:0]          block_counter_i,
  input  logic                T1_i,
  input  logic [8:0]          T1_offset_i,
  input  logic [LEN_BITS-1:0] T1_length_i,
  input  logic                enable_i,
  input  logic                blk_ack_i,
  output logic                T1_mask_o,
  output logic                blk_req_o,
  output logic [8:0]          blk_addr_o,
  output logic                blk_last_o,
  output logic                evt_drop_o,
  output logic [15:0]         evt_count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, REQ} state_t;

  logic [8:0]          start_mem [FIFO_DEPTH];
  logic [LEN_BITS-1:0] len_mem   [FIFO_DEPTH];

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      count_q, count_d;
  logic [8:0]          addr_q, addr_d;
  logic [LEN_BITS-1:0] rem_q, rem_d;
  logic                mask_q, mask_d;
  logic                drop_q, drop_d;
  logic [15:0]         evt_count_q, evt_count_d;

  logic                full, empty, push, pop;
  logic [8:0]          stamp_start;
  logic [LEN_BITS-1:0] stamp_len;

  assign stamp_start = block_counter_i - T1_offset_i;
  assign stamp_len   = (T1_length_i == '0) ? LEN_BITS'(1) : T1_length_i;

  assign full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign pop   = (state_q == IDLE) && !empty && enable_i;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push  = T1_i && (!full || pop);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    evt_count_d = evt_count_q;

    if (push) begin
      wr_ptr_d    = wr_ptr_q + PTR_W'(1);
      evt_count_d = evt_count_q + 16'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase

    mask_d = (count_d == (PTR_W+1)'(FIFO_DEPTH));
    drop_d = T1_i && !push;

    case (state_q)
      IDLE: begin
        if (pop) begin
          addr_d  = start_mem[rd_ptr_q];
          rem_d   = len_mem[rd_ptr_q];
          state_d = REQ;
        end
      end
      REQ: begin
        if (blk_ack_i) begin
          if (rem_q > LEN_BITS'(1)) begin
            addr_d = addr_q + 9'd1;
            rem_d  = rem_q - LEN_BITS'(1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      addr_q      <= '0;
      mask_q      <= 1'b0;
      drop_q      <= 1'b0;
      evt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      mask_q      <= mask_d;
      drop_q      <= drop_d;
      evt_count_q <= evt_count_d;
    end
  end

  // Payload storage is qualified by the pointers/state, so it carries no reset.
  always_ff @(posedge clk_i) begin
    rem_q <= rem_d;
    if (push) begin
      start_mem[wr_ptr_q] <= stamp_start;
      len_mem[wr_ptr_q]   <= stamp_len;
    end
  end

  assign blk_req_o   = (state_q == REQ);
  assign blk_last_o  = blk_req_o && (rem_q == LEN_BITS'(1));
  assign blk_addr_o  = addr_q;
  assign T1_mask_o   = mask_q;
  assign evt_drop_o  = drop_q;
  assign evt_count_o = evt_count_q;

endmodule

// File: tb/tb_t1_block_scheduler.sv
// Directed bench for t1_block_scheduler: a scoreboard holds the expected block
// transfers for every accepted T1 and a negedge monitor retires them on each handshake.
module tb_t1_block_scheduler;

  localparam int FIFO_DEPTH = 4;
  localparam int LEN_BITS   = 4;

  logic                clk;
  logic                rst_i;
  logic [8:0]          block_counter_i;
  logic                T1_i;
  logic [8:0]          T1_offset_i;
  logic [LEN_BITS-1:0] T1_length_i;
  logic                enable_i;
  logic                blk_ack_i;
  logic                T1_mask_o;
  logic                blk_req_o;
  logic [8:0]          blk_addr_o;
  logic                blk_last_o;
  logic                evt_drop_o;
  logic [15:0]         evt_count_o;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  logic [9:0] sb[$];

  t1_block_scheduler #(.FIFO_DEPTH(FIFO_DEPTH), .LEN_BITS(LEN_BITS)) dut (
    .clk_i(clk), .rst_i(rst_i), .block_counter_i(block_counter_i), .T1_i(T1_i),
    .T1_offset_i(T1_offset_i), .T1_length_i(T1_length_i), .enable_i(enable_i),
    .blk_ack_i(blk_ack_i), .T1_mask_o(T1_mask_o), .blk_req_o(blk_req_o),
    .blk_addr_o(blk_addr_o), .blk_last_o(blk_last_o), .evt_drop_o(evt_drop_o),
    .evt_count_o(evt_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int bc, input int off, input int len, input bit accept);
    int s;
    int n;
    block_counter_i = 9'(bc);
    T1_offset_i     = 9'(off);
    T1_length_i     = LEN_BITS'(len);
    T1_i            = 1'b1;
    if (accept) begin
      s = (bc - off) & 511;
      n = (len == 0) ? 1 : len;
      for (int k = 0; k < n; k++) sb.push_back({(k == n - 1), 9'((s + k) & 511)});
      exp_count++;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || blk_req_o) && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_drain"}, sb.size(), 0);
  endtask

  // Handshake monitor: retires scoreboard entries and checks address hold under backpressure.
  initial begin
    logic       prev_hold;
    logic [8:0] prev_addr;
    logic [9:0] e;
    prev_hold = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (blk_req_o && prev_hold) chk("addr_stable", blk_addr_o, prev_addr);
      if (blk_req_o && blk_ack_i && !rst_i) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_xfer", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("sb_addr", blk_addr_o, e[8:0]);
          chk("sb_last", blk_last_o, e[9]);
        end
      end
      prev_hold = blk_req_o && !blk_ack_i && !rst_i;
      prev_addr = blk_addr_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1; T1_i = 1'b0; block_counter_i = '0; T1_offset_i = '0;
    T1_length_i = '0; enable_i = 1'b1; blk_ack_i = 1'b0;
    tick();
    tick();
    chk("rst_req", blk_req_o, 0);
    chk("rst_last", blk_last_o, 0);
    chk("rst_mask", T1_mask_o, 0);
    chk("rst_drop", evt_drop_o, 0);
    chk("rst_addr", blk_addr_o, 0);
    chk("rst_count", evt_count_o, 0);
    rst_i = 1'b0;
    tick();

    // single event, 2-cycle latency, ack held high
    blk_ack_i = 1'b1;
    send(100, 10, 3, 1);
    tick();
    T1_i = 1'b0;
    chk("single_req_n1", blk_req_o, 0);
    tick();
    chk("single_req_n2", blk_req_o, 1);
    chk("single_addr_n2", blk_addr_o, 90);
    chk("single_last_n2", blk_last_o, 0);
    tick();
    chk("single_addr_n3", blk_addr_o, 91);
    tick();
    chk("single_addr_n4", blk_addr_o, 92);
    chk("single_last_n4", blk_last_o, 1);
    tick();
    chk("single_req_n5", blk_req_o, 0);
    chk("single_count", evt_count_o, exp_count);

    // address wrap 511 -> 0, then zero length as one block
    send(5, 8, 4, 1);
    tick();
    T1_i = 1'b0;
    drain("wrap");
    send(20, 0, 0, 1);
    tick();
    T1_i = 1'b0;
    tick();
    chk("len0_req", blk_req_o, 1);
    chk("len0_addr", blk_addr_o, 20);
    chk("len0_last", blk_last_o, 1);
    drain("len0");

    // backpressure: hold, then ack every other cycle
    blk_ack_i = 1'b0;
    send(200, 0, 3, 1);
    tick();
    T1_i = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_held", blk_req_o, 1);
      chk("bp_addr_held", blk_addr_o, 200);
      tick();
    end
    for (int i = 0; i < 40 && (sb.size() != 0 || blk_req_o); i++) begin
      blk_ack_i = ~blk_ack_i;
      tick();
    end
    chk("bp_drain", sb.size(), 0);
    chk("bp_count", evt_count_o, exp_count);

    // full FIFO: mask and drop
    blk_ack_i = 1'b0;
    for (int i = 0; i < FIFO_DEPTH + 2; i++) begin
      send(300 + i, 0, 1, i < FIFO_DEPTH + 1);
      tick();
      if (i == FIFO_DEPTH - 1) chk("full_mask_before", T1_mask_o, 0);
      if (i == FIFO_DEPTH) chk("full_mask_set", T1_mask_o, 1);
    end
    T1_i = 1'b0;
    chk("full_drop_pulse", evt_drop_o, 1);
    chk("full_count", evt_count_o, exp_count);
    chk("full_mask_hold", T1_mask_o, 1);
    tick();
    chk("full_drop_once", evt_drop_o, 0);
    blk_ack_i = 1'b1;
    tick();
    chk("full_mask_at_pop", T1_mask_o, 1);
    chk("full_idle_gap", blk_req_o, 0);
    tick();
    chk("full_mask_fall", T1_mask_o, 0);
    chk("full_req_next", blk_req_o, 1);
    drain("full");

    // simultaneous write and pop while full
    blk_ack_i = 1'b0;
    enable_i  = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      send(400 + 10 * i, 0, 2, 1);
      tick();
    end
    chk("simul_mask_full", T1_mask_o, 1);
    enable_i = 1'b1;
    send(450, 0, 1, 1);
    tick();
    T1_i = 1'b0;
    chk("simul_drop", evt_drop_o, 0);
    chk("simul_mask_stays", T1_mask_o, 1);
    chk("simul_req", blk_req_o, 1);
    chk("simul_count", evt_count_o, exp_count);
    blk_ack_i = 1'b1;
    drain("simul");

    // reset during the 2nd block of a 4-block event, ack high in the reset cycle
    send(50, 0, 4, 1);
    tick();
    T1_i = 1'b0;
    tick();
    tick();
    chk("rmid_addr_2nd", blk_addr_o, 51);
    rst_i = 1'b1;
    tick();
    sb.delete();
    exp_count = 0;
    chk("rmid_req", blk_req_o, 0);
    chk("rmid_last", blk_last_o, 0);
    chk("rmid_mask", T1_mask_o, 0);
    chk("rmid_drop", evt_drop_o, 0);
    chk("rmid_addr", blk_addr_o, 0);
    chk("rmid_count", evt_count_o, 0);
    rst_i = 1'b0;
    send(60, 5, 2, 1);
    tick();
    T1_i = 1'b0;
    chk("post_rst_req_n1", blk_req_o, 0);
    tick();
    chk("post_rst_req_n2", blk_req_o, 1);
    chk("post_rst_addr", blk_addr_o, 55);
    drain("post_rst");
    chk("post_rst_count", evt_count_o, exp_count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
